instr_decode_pipe: RTL and testbench

Parametrised decode stage for the 3-bit chronospatial CPU (ADV/BXL/BST/JNZ/BXC/OUT/BDV/CDV). It sits between fetch and execute, with valid/ready handshakes on both sides and a 2-entry skid buffer. The block resolves combo operands to a source select, widens literals to DATA_W, carries the PC, flags illegal combo operand 7, and supports halt and jump flush.

---
 rtl/cpu3_pkg.sv | 50 +++++
 rtl/decode_comb.sv | 57 +++++
 rtl/instr_decode_pipe.sv | 155 +++++++++++++++
 tb/tb_instr_decode_pipe.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu3_pkg.sv
// Shared encodings for the 3-bit chronospatial CPU decode path.
package cpu3_pkg;

  // Opcodes
  localparam logic [2:0] ADV = 3'd0;
  localparam logic [2:0] BXL = 3'd1;
  localparam logic [2:0] BST = 3'd2;
  localparam logic [2:0] JNZ = 3'd3;
  localparam logic [2:0] BXC = 3'd4;
  localparam logic [2:0] OUT = 3'd5;
  localparam logic [2:0] BDV = 3'd6;
  localparam logic [2:0] CDV = 3'd7;

  // ALU operand source selects
  localparam logic [1:0] REG_A_OP = 2'd0;
  localparam logic [1:0] REG_B_OP = 2'd1;
  localparam logic [1:0] REG_C_OP = 2'd2;
  localparam logic [1:0] REG_O_OP = 2'd3;

  // Operation selects
  localparam logic [1:0] SHIFT_SEL = 2'd0;
  localparam logic [1:0] XOR_SEL   = 2'd1;
  localparam logic [1:0] MOD_SEL   = 2'd2;
  localparam logic [1:0] JUMP_SEL  = 2'd3;

  // Combo operand sources
  localparam logic [1:0] COMBO_IMM = 2'd0;
  localparam logic [1:0] COMBO_A   = 2'd1;
  localparam logic [1:0] COMBO_B   = 2'd2;
  localparam logic [1:0] COMBO_C   = 2'd3;

  // One-hot register write enables {OUT,C,B,A}
  localparam logic [3:0] REG_A_WR_EN = 4'b0001;
  localparam logic [3:0] REG_B_WR_EN = 4'b0010;
  localparam logic [3:0] REG_C_WR_EN = 4'b0100;
  localparam logic [3:0] REG_O_WR_EN = 4'b1000;
  localparam logic [3:0] NO_WR_EN    = 4'b0000;

  // One decoded micro-op; the operand is kept raw and widened at the output.
  typedef struct packed {
    logic [1:0] op1;
    logic [1:0] op2;
    logic [1:0] op;
    logic [1:0] combo;
    logic [3:0] wr;
    logic [2:0] operand;
    logic       illegal;
  } entry_t;

endpackage

// File: rtl/decode_comb.sv
// Pure combinational opcode/operand to micro-op translation.
// Fields an opcode does not use keep the previous entry's value to avoid toggling.
module decode_comb
  import cpu3_pkg::*;
(
  input  logic [2:0] opcode_i,
  input  logic [2:0] operand_i,
  input  logic [1:0] prev_op1_i,
  input  logic [1:0] prev_op2_i,
  input  logic [1:0] prev_combo_i,
  output entry_t     ent_o
);

  logic is_combo;

  // Translate opcode, then resolve the combo operand for combo-using ops.
  always_comb begin
    ent_o         = '0;
    ent_o.op1     = prev_op1_i;
    ent_o.op2     = prev_op2_i;
    ent_o.combo   = prev_combo_i;
    ent_o.operand = operand_i;
    is_combo      = 1'b0;
    case (opcode_i)
      ADV: begin ent_o.op = SHIFT_SEL; ent_o.wr = REG_A_WR_EN; is_combo = 1'b1; end
      BXL: begin
        ent_o.op1 = REG_B_OP; ent_o.op2 = REG_O_OP;
        ent_o.op  = XOR_SEL;  ent_o.wr  = REG_B_WR_EN;
      end
      BST: begin
        ent_o.op1 = REG_O_OP; ent_o.op = MOD_SEL; ent_o.wr = REG_B_WR_EN; is_combo = 1'b1;
      end
      JNZ: begin ent_o.op = JUMP_SEL; ent_o.wr = NO_WR_EN; end
      BXC: begin
        ent_o.op1 = REG_B_OP; ent_o.op2 = REG_C_OP;
        ent_o.op  = XOR_SEL;  ent_o.wr  = REG_B_WR_EN;
      end
      OUT: begin
        ent_o.op1 = REG_O_OP; ent_o.op = MOD_SEL; ent_o.wr = REG_O_WR_EN; is_combo = 1'b1;
      end
      BDV: begin ent_o.op = SHIFT_SEL; ent_o.wr = REG_B_WR_EN; is_combo = 1'b1; end
      default: begin ent_o.op = SHIFT_SEL; ent_o.wr = REG_C_WR_EN; is_combo = 1'b1; end
    endcase
    if (is_combo) begin
      if (!operand_i[2]) begin
        ent_o.combo = COMBO_IMM;
      end else if (operand_i == 3'd7) begin
        ent_o.illegal = 1'b1;
        ent_o.wr      = NO_WR_EN;
      end else begin
        // 4/5/6 map onto A/B/C
        ent_o.combo = operand_i[1:0] + 2'd1;
      end
    end
  end

endmodule

// File: rtl/instr_decode_pipe.sv
// Decode stage between fetch and execute with a 2-entry skid buffer,
// halt freeze, jump flush and illegal-operand lockout.
//
// Handshake: a beat moves on a side only in a cycle where that side's valid
// and ready are both 1 at the clock edge. in_ready is registered (gated by
// halt); dec_* are held stable while dec_valid=1 and dec_ready=0.
module instr_decode_pipe
  import cpu3_pkg::*;
#(
  parameter int DATA_W       = 48,
  parameter int PC_W         = 8,
  parameter int ILLEGAL_HALT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              halt,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_opcode,
  input  logic [2:0]        in_operand,
  input  logic [PC_W-1:0]   in_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [1:0]        dec_op1_sel,
  output logic [1:0]        dec_op2_sel,
  output logic [1:0]        dec_operation_sel,
  output logic [1:0]        dec_combo_sel,
  output logic [3:0]        dec_reg_wr_en,
  output logic [DATA_W-1:0] dec_imm,
  output logic [PC_W-1:0]   dec_pc,
  output logic              dec_illegal,
  output logic              err_illegal
);

  entry_t            main_q, main_d, skid_q, skid_d, dec_ent;
  logic [PC_W-1:0]   main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic              main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic              in_ready_q, in_ready_d;
  logic              lock_q, lock_d, err_q, err_d;
  logic [1:0]        last_op1_q, last_op1_d, last_op2_q, last_op2_d;
  logic [1:0]        last_combo_q, last_combo_d;
  logic              accept, drain;

  decode_comb u_decode (
    .opcode_i     (in_opcode),
    .operand_i    (in_operand),
    .prev_op1_i   (last_op1_q),
    .prev_op2_i   (last_op2_q),
    .prev_combo_i (last_combo_q),
    .ent_o        (dec_ent)
  );

  assign in_ready = in_ready_q & ~halt;
  assign accept   = in_valid & in_ready;
  assign drain    = main_v_q & dec_ready & ~halt;

  // Buffer movement: flush beats accept/drain; halt freezes everything.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_pc_d    = main_pc_q;
    skid_pc_d    = skid_pc_q;
    main_v_d     = main_v_q;
    skid_v_d     = skid_v_q;
    lock_d       = lock_q;
    err_d        = err_q;
    last_op1_d   = last_op1_q;
    last_op2_d   = last_op2_q;
    last_combo_d = last_combo_q;
    in_ready_d   = in_ready_q;
    if (!halt) begin
      if (flush) begin
        main_v_d = 1'b0;
        skid_v_d = 1'b0;
      end else begin
        if (accept) begin
          last_op1_d   = dec_ent.op1;
          last_op2_d   = dec_ent.op2;
          last_combo_d = dec_ent.combo;
          if (dec_ent.illegal) begin
            err_d = 1'b1;
            if (ILLEGAL_HALT != 0) lock_d = 1'b1;
          end
        end
        if (!main_v_q || drain) begin
          if (skid_v_q) begin
            main_d    = skid_q;
            main_pc_d = skid_pc_q;
            main_v_d  = 1'b1;
            skid_v_d  = accept;
            if (accept) begin
              skid_d    = dec_ent;
              skid_pc_d = in_pc;
            end
          end else begin
            main_v_d = accept;
            if (accept) begin
              main_d    = dec_ent;
              main_pc_d = in_pc;
            end
          end
        end else if (accept) begin
          skid_d    = dec_ent;
          skid_pc_d = in_pc;
          skid_v_d  = 1'b1;
        end
      end
      in_ready_d = ~skid_v_d & ~lock_d;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_pc_q    <= '0;
      skid_pc_q    <= '0;
      main_v_q     <= 1'b0;
      skid_v_q     <= 1'b0;
      in_ready_q   <= 1'b1;
      lock_q       <= 1'b0;
      err_q        <= 1'b0;
      last_op1_q   <= '0;
      last_op2_q   <= '0;
      last_combo_q <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_pc_q    <= main_pc_d;
      skid_pc_q    <= skid_pc_d;
      main_v_q     <= main_v_d;
      skid_v_q     <= skid_v_d;
      in_ready_q   <= in_ready_d;
      lock_q       <= lock_d;
      err_q        <= err_d;
      last_op1_q   <= last_op1_d;
      last_op2_q   <= last_op2_d;
      last_combo_q <= last_combo_d;
    end
  end

  assign dec_valid         = main_v_q;
  assign dec_op1_sel       = main_q.op1;
  assign dec_op2_sel       = main_q.op2;
  assign dec_operation_sel = main_q.op;
  assign dec_combo_sel     = main_q.combo;
  assign dec_reg_wr_en     = main_q.wr;
  assign dec_imm           = {{(DATA_W-3){1'b0}}, main_q.operand};
  assign dec_pc            = main_pc_q;
  assign dec_illegal       = main_q.illegal;
  assign err_illegal       = err_q;

endmodule

// File: tb/tb_instr_decode_pipe.sv
// Directed bench for instr_decode_pipe with an expected-queue scoreboard.
module tb_instr_decode_pipe;

  localparam int DATA_W = 48;
  localparam int PC_W   = 8;
  localparam int W      = 27;

  logic              clk = 1'b0;
  logic              rstn, halt, flush, in_valid, in_ready, dec_valid, dec_ready;
  logic [2:0]        in_opcode, in_operand;
  logic [PC_W-1:0]   in_pc, dec_pc;
  logic [1:0]        dec_op1_sel, dec_op2_sel, dec_operation_sel, dec_combo_sel;
  logic [3:0]        dec_reg_wr_en;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_illegal, err_illegal;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  instr_decode_pipe #(.DATA_W(DATA_W), .PC_W(PC_W), .ILLEGAL_HALT(1)) dut (
    .clk(clk), .rstn(rstn), .halt(halt), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_operand(in_operand), .in_pc(in_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_op1_sel(dec_op1_sel), .dec_op2_sel(dec_op2_sel),
    .dec_operation_sel(dec_operation_sel), .dec_combo_sel(dec_combo_sel),
    .dec_reg_wr_en(dec_reg_wr_en), .dec_imm(dec_imm), .dec_pc(dec_pc),
    .dec_illegal(dec_illegal), .err_illegal(err_illegal)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected item: {check mask (op1,op2,combo), op1, op2, op, combo, wr, operand, pc, illegal}
  function automatic logic [W-1:0] mk(input logic [2:0] mask, input logic [1:0] op1,
                                      input logic [1:0] op2, input logic [1:0] op,
                                      input logic [1:0] combo, input logic [3:0] wr,
                                      input logic [2:0] opd, input logic [7:0] pc,
                                      input logic ill);
    return {mask, op1, op2, op, combo, wr, opd, pc, ill};
  endfunction

  // driver: present one instruction, wait (bounded) for acceptance
  task automatic send(input logic [2:0] opc, input logic [2:0] opd, input logic [7:0] pc,
                      input logic [W-1:0] e, input bit push);
    int n;
    n = 0;
    in_valid = 1'b1; in_opcode = opc; in_operand = opd; in_pc = pc;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", {63'b0, in_ready}, 64'd1);
    else if (push) exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor / scoreboard: compare every output transfer against the queue head
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rstn && dec_valid && dec_ready && !halt) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got pc %0h, no entry expected", dec_pc);
      end else begin
        e = exp_q.pop_front();
        if (e[26]) chk("op1_sel", dec_op1_sel, e[23:22]);
        if (e[25]) chk("op2_sel", dec_op2_sel, e[21:20]);
        if (e[24]) chk("combo_sel", dec_combo_sel, e[17:16]);
        chk("operation_sel", dec_operation_sel, e[19:18]);
        chk("reg_wr_en", dec_reg_wr_en, e[15:12]);
        chk("imm", dec_imm, {61'b0, e[11:9]});
        chk("pc", dec_pc, e[8:1]);
        chk("illegal", dec_illegal, e[0]);
      end
    end
  end

  initial begin
    int n;
    rstn = 1'b0; halt = 1'b0; flush = 1'b0; in_valid = 1'b0; dec_ready = 1'b1;
    in_opcode = 3'd0; in_operand = 3'd0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_err", err_illegal, 0);
    chk("rst_wr", dec_reg_wr_en, 0);
    chk("rst_imm", dec_imm, 0);
    chk("rst_pc", dec_pc, 0);
    rstn = 1'b1;
    idle(1);

    // single BXL 5 at pc 3, visible the cycle after acceptance
    send(3'd1, 3'd5, 8'd3, mk(3'b110, 2'd1, 2'd3, 2'd1, 2'd0, 4'b0010, 3'd5, 8'd3, 1'b0), 1);
    chk("lat_dec_valid", dec_valid, 1);
    idle(2);

    // back-to-back stream of combo ops
    send(3'd0, 3'd2, 8'd10, mk(3'b001, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0001, 3'd2, 8'd10, 1'b0), 1);
    chk("stream_in_ready0", in_ready, 1);
    send(3'd2, 3'd4, 8'd11, mk(3'b101, 2'd3, 2'd0, 2'd2, 2'd1, 4'b0010, 3'd4, 8'd11, 1'b0), 1);
    chk("stream_in_ready1", in_ready, 1);
    send(3'd5, 3'd6, 8'd12, mk(3'b101, 2'd3, 2'd0, 2'd2, 2'd3, 4'b1000, 3'd6, 8'd12, 1'b0), 1);
    chk("stream_in_ready2", in_ready, 1);
    send(3'd7, 3'd5, 8'd13, mk(3'b001, 2'd0, 2'd0, 2'd0, 2'd2, 4'b0100, 3'd5, 8'd13, 1'b0), 1);
    chk("stream_in_ready3", in_ready, 1);
    idle(3);

    // backpressure: two accepted, third waits
    dec_ready = 1'b0;
    send(3'd4, 3'd0, 8'd20, mk(3'b110, 2'd1, 2'd2, 2'd1, 2'd0, 4'b0010, 3'd0, 8'd20, 1'b0), 1);
    send(3'd3, 3'd0, 8'd21, mk(3'b000, 2'd0, 2'd0, 2'd3, 2'd0, 4'b0000, 3'd0, 8'd21, 1'b0), 1);
    chk("bp_in_ready_full", in_ready, 0);
    in_valid = 1'b1; in_opcode = 3'd6; in_operand = 3'd1; in_pc = 8'd22;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready_hold", in_ready, 0);
      chk("bp_dec_valid_hold", dec_valid, 1);
      chk("bp_dec_pc_hold", dec_pc, 8'd20);
    end
    @(posedge clk); #1;
    dec_ready = 1'b1;
    send(3'd6, 3'd1, 8'd22, mk(3'b001, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0010, 3'd1, 8'd22, 1'b0), 1);
    idle(4);

    // flush with both entries full and a concurrent (blocked) input
    dec_ready = 1'b0;
    send(3'd1, 3'd1, 8'd30, '0, 0);
    send(3'd1, 3'd2, 8'd31, '0, 0);
    in_valid = 1'b1; in_opcode = 3'd1; in_operand = 3'd3; in_pc = 8'd32; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush2_dec_valid", dec_valid, 0);
    chk("flush2_in_ready", in_ready, 1);
    dec_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush2_stay_empty", dec_valid, 0);
    end
    @(posedge clk); #1;

    // flush with one entry and a concurrent accepted input
    dec_ready = 1'b0;
    send(3'd4, 3'd0, 8'd33, '0, 0);
    in_valid = 1'b1; in_opcode = 3'd0; in_operand = 3'd1; in_pc = 8'd34; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush1_dec_valid", dec_valid, 0);
    chk("flush1_in_ready", in_ready, 1);
    dec_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("flush1_stay_empty", dec_valid, 0);
    end
    @(posedge clk); #1;

    // halt holds a valid entry despite dec_ready and a flush
    dec_ready = 1'b0;
    send(3'd1, 3'd3, 8'd40, mk(3'b110, 2'd1, 2'd3, 2'd1, 2'd0, 4'b0010, 3'd3, 8'd40, 1'b0), 1);
    in_valid = 1'b0;
    halt = 1'b1; dec_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      flush = (i == 1);
      @(negedge clk);
      chk("halt_in_ready", in_ready, 0);
      chk("halt_dec_valid", dec_valid, 1);
      chk("halt_dec_pc", dec_pc, 8'd40);
    end
    @(posedge clk); #1;
    flush = 1'b0; halt = 1'b0;
    @(posedge clk); #1;
    chk("halt_released_empty", dec_valid, 0);
    chk("halt_released_ready", in_ready, 1);
    idle(2);

    // illegal combo operand 7 and lockout until reset
    send(3'd0, 3'd7, 8'd50, mk(3'b000, 2'd0, 2'd0, 2'd0, 2'd0, 4'b0000, 3'd7, 8'd50, 1'b1), 1);
    chk("ill_err", err_illegal, 1);
    chk("ill_in_ready", in_ready, 0);
    in_valid = 1'b1; in_opcode = 3'd1; in_operand = 3'd1; in_pc = 8'd51;
    repeat (3) begin
      @(negedge clk);
      chk("ill_lockout", in_ready, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("rst2_err", err_illegal, 0);
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_dec_valid", dec_valid, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(1);

    // recovery after reset
    send(3'd2, 3'd5, 8'd60, mk(3'b101, 2'd3, 2'd0, 2'd2, 2'd2, 4'b0010, 3'd5, 8'd60, 1'b0), 1);
    idle(3);

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      n++;
      @(posedge clk);
    end
    chk("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
